// File: rtl/pong_frame_renderer.sv
// Pong pixel generator placed after the CRT timing controller.
// It advances the game state once per frame, on the falling edge of vsync.
// It outputs registered 12-bit RGB together with the syncs delayed by one clock.
module pong_frame_renderer #(
    parameter int ResolutionSize = 10,
    parameter int BallSize       = 8,
    parameter int PaddleWidth    = 8,
    parameter int PaddleHeight   = 48,
    parameter int PaddleStep     = 4,
    parameter int PaddleInset    = 16,
    parameter int ServeDelay     = 60
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ResolutionSize-1:0] Xresolution,
    input  logic [ResolutionSize-1:0] Yresolution,
    input  logic [ResolutionSize-1:0] xpos,
    input  logic [ResolutionSize-1:0] ypos,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      btnLup,
    input  logic                      btnLdown,
    input  logic                      btnRup,
    input  logic                      btnRdown,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic [3:0]                red,
    output logic [3:0]                green,
    output logic [3:0]                blue,
    output logic [3:0]                scoreL,
    output logic [3:0]                scoreR
);
    localparam int W  = ResolutionSize;
    localparam int W1 = ResolutionSize + 1;
    localparam int CW = (ServeDelay > 1) ? $clog2(ServeDelay) : 1;

    // One spare bit on all geometry sums so that "+ size" never wraps.
    localparam logic [W1-1:0] BALL  = W1'(BallSize);
    localparam logic [W1-1:0] PW    = W1'(PaddleWidth);
    localparam logic [W1-1:0] PH    = W1'(PaddleHeight);
    localparam logic [W1-1:0] STEP  = W1'(PaddleStep);
    localparam logic [W1-1:0] INSET = W1'(PaddleInset);
    localparam logic [CW-1:0] SERVE_LAST = CW'(ServeDelay - 1);

    typedef enum logic {SERVE = 1'b0, PLAY = 1'b1} state_t;

    state_t        state, state_n;
    logic          vs_d, frame_tick;
    logic [W-1:0]  bx, by, ly, ry, bx_n, by_n, ly_n, ry_n;
    logic          dx, dy, dx_n, dy_n;
    logic [CW-1:0] serve_cnt, serve_cnt_n;
    logic [3:0]    scoreL_n, scoreR_n;
    logic [11:0]   rgb_p0;

    logic [W1-1:0] xres, yres, bx_w, by_w, ly_w, ry_w, x_w, y_w, rpad_x, pad_ymax;
    logic [W-1:0]  ball_cx, ball_cy, pad_cy;

    assign xres     = {1'b0, Xresolution};
    assign yres     = {1'b0, Yresolution};
    assign bx_w     = {1'b0, bx};
    assign by_w     = {1'b0, by};
    assign ly_w     = {1'b0, ly};
    assign ry_w     = {1'b0, ry};
    assign x_w      = {1'b0, xpos};
    assign y_w      = {1'b0, ypos};
    assign rpad_x   = xres - INSET - PW;
    assign pad_ymax = yres - PH;
    assign ball_cx  = W'((xres - BALL) >> 1);
    assign ball_cy  = W'((yres - BALL) >> 1);
    assign pad_cy   = W'(pad_ymax >> 1);

    assign frame_tick = vs_d & ~vsync_in;

    // Move a paddle by one step, clamped to the range [0, ymax].
    // Pressing both buttons, or neither, leaves the paddle where it is.
    function automatic logic [W-1:0] paddle_move(input logic [W-1:0] y, input logic up,
                                                 input logic down, input logic [W1-1:0] ymax);
        logic [W1-1:0] yw;
        yw = {1'b0, y};
        if (up && !down)
            return (yw < STEP) ? '0 : W'(yw - STEP);
        if (down && !up)
            return (yw + STEP > ymax) ? W'(ymax) : W'(yw + STEP);
        return y;
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic overlaps(input logic [W1-1:0] ball_y, input logic [W1-1:0] pad_y);
        return (ball_y + BALL > pad_y) && (ball_y < pad_y + PH);
    endfunction

    // Next game state for the coming frame tick. Every term reads the current register values.
    always_comb begin
        state_n     = state;
        bx_n        = bx;
        by_n        = by;
        dx_n        = dx;
        dy_n        = dy;
        serve_cnt_n = serve_cnt;
        scoreL_n    = scoreL;
        scoreR_n    = scoreR;
        ly_n        = paddle_move(ly, btnLup, btnLdown, pad_ymax);
        ry_n        = paddle_move(ry, btnRup, btnRdown, pad_ymax);
        case (state)
            SERVE: begin
                bx_n = ball_cx;
                by_n = ball_cy;
                if (serve_cnt == SERVE_LAST) begin
                    serve_cnt_n = '0;
                    state_n     = PLAY;
                end else begin
                    serve_cnt_n = serve_cnt + 1'b1;
                end
            end
            PLAY: begin
                if (!dy && by_w == '0)
                    dy_n = 1'b1;
                else if (dy && by_w + BALL == yres)
                    dy_n = 1'b0;
                else
                    by_n = dy ? by + 1'b1 : by - 1'b1;

                if (!dx && bx_w == INSET + PW && overlaps(by_w, ly_w)) begin
                    dx_n = 1'b1;
                end else if (dx && bx_w + BALL == rpad_x && overlaps(by_w, ry_w)) begin
                    dx_n = 1'b0;
                end else if (!dx && bx_w == '0) begin
                    scoreR_n = bcd_inc(scoreR);
                    dx_n     = 1'b0;
                    state_n  = SERVE;
                    bx_n     = ball_cx;
                    by_n     = ball_cy;
                end else if (dx && bx_w + BALL == xres) begin
                    scoreL_n = bcd_inc(scoreL);
                    dx_n     = 1'b1;
                    state_n  = SERVE;
                    bx_n     = ball_cx;
                    by_n     = ball_cy;
                end else begin
                    bx_n = dx ? bx + 1'b1 : bx - 1'b1;
                end
            end
            default: state_n = SERVE;
        endcase
    end

    // Game state register. Reset takes priority, and the state commits only on a frame tick.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vs_d      <= 1'b1;
            state     <= SERVE;
            serve_cnt <= '0;
            bx        <= ball_cx;
            by        <= ball_cy;
            dx        <= 1'b1;
            dy        <= 1'b1;
            ly        <= pad_cy;
            ry        <= pad_cy;
            scoreL    <= 4'd0;
            scoreR    <= 4'd0;
        end else begin
            vs_d <= vsync_in;
            if (frame_tick) begin
                state     <= state_n;
                serve_cnt <= serve_cnt_n;
                bx        <= bx_n;
                by        <= by_n;
                dx        <= dx_n;
                dy        <= dy_n;
                ly        <= ly_n;
                ry        <= ry_n;
                scoreL    <= scoreL_n;
                scoreR    <= scoreR_n;
            end
        end
    end

    // Pixel colour for the current coordinate.
    // Priority order: ball, then paddles, then the dashed centre line.
    always_comb begin
        rgb_p0 = 12'h000;
        if (x_w < xres && y_w < yres) begin
            if (x_w >= bx_w && x_w < bx_w + BALL && y_w >= by_w && y_w < by_w + BALL)
                rgb_p0 = 12'hFFF;
            else if ((x_w >= INSET && x_w < INSET + PW && y_w >= ly_w && y_w < ly_w + PH) ||
                     (x_w >= rpad_x && x_w < xres - INSET && y_w >= ry_w && y_w < ry_w + PH))
                rgb_p0 = 12'h0F0;
            else if (x_w == (xres >> 1) && !ypos[3])
                rgb_p0 = 12'h444;
        end
    end

    // Output register. The syncs are delayed alongside the colour so both reach the connector aligned.
    always_ff @(posedge clock) begin
        if (!reset) begin
            {red, green, blue} <= 12'h000;
            hsync_out          <= 1'b1;
            vsync_out          <= 1'b1;
        end else begin
            {red, green, blue} <= rgb_p0;
            hsync_out          <= hsync_in;
            vsync_out          <= vsync_in;
        end
    end
endmodule

// File: tb/tb_pong_frame_renderer.sv
// Bench for pong_frame_renderer.
// A behavioural game model, written in plain integer arithmetic, tracks the expected state on every frame tick.
module tb_pong_frame_renderer;
    localparam int SD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] Xresolution, Yresolution, xpos, ypos;
    logic       hsync_in, vsync_in, btnLup, btnLdown, btnRup, btnRdown;
    logic       hsync_out, vsync_out;
    logic [3:0] red, green, blue, scoreL, scoreR;

    int checks = 0;
    int failures = 0;

    // model state
    int xr, yr;
    int m_bx, m_by, m_ly, m_ry, m_dx, m_dy, m_play, m_cnt, m_sl, m_sr;
    int ev_hit = 0, ev_miss = 0, ev_wrap = 0;

    pong_frame_renderer #(.ServeDelay(SD)) dut (
        .clock(clock), .reset(reset),
        .Xresolution(Xresolution), .Yresolution(Yresolution),
        .xpos(xpos), .ypos(ypos),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .btnLup(btnLup), .btnLdown(btnLdown), .btnRup(btnRup), .btnRdown(btnRdown),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .red(red), .green(green), .blue(blue),
        .scoreL(scoreL), .scoreR(scoreR)
    );

    always #5 clock = ~clock;

    function automatic int move_paddle(int y, bit up, bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > yr - 48) ? yr - 48 : y + 4;
        return y;
    endfunction

    task automatic m_reset();
        m_bx = (xr - 8) / 2;  m_by = (yr - 8) / 2;
        m_ly = (yr - 48) / 2; m_ry = (yr - 48) / 2;
        m_dx = 1; m_dy = 1; m_play = 0; m_cnt = 0; m_sl = 0; m_sr = 0;
    endtask

    task automatic m_tick(bit lu, bit ld, bit ru, bit rd);
        int nbx, nby, ndx, ndy;
        bit ovl, ovr, miss;
        nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy; miss = 0;
        if (!m_play) begin
            nbx = (xr - 8) / 2; nby = (yr - 8) / 2;
            if (m_cnt == SD - 1) begin m_cnt = 0; m_play = 1; end
            else m_cnt++;
        end else begin
            ovl = (m_by + 8 > m_ly) && (m_by < m_ly + 48);
            ovr = (m_by + 8 > m_ry) && (m_by < m_ry + 48);
            if (m_dy == 0 && m_by == 0) ndy = 1;
            else if (m_dy == 1 && m_by + 8 == yr) ndy = 0;
            else nby = m_by + (m_dy ? 1 : -1);
            if (m_dx == 0 && m_bx == 24 && ovl) begin ndx = 1; ev_hit++; end
            else if (m_dx == 1 && m_bx + 8 == xr - 24 && ovr) begin ndx = 0; ev_hit++; end
            else if (m_dx == 0 && m_bx == 0) begin
                m_sr = (m_sr + 1) % 10; ndx = 0; miss = 1;
                if (m_sr == 0) ev_wrap++;
            end else if (m_dx == 1 && m_bx + 8 == xr) begin
                m_sl = (m_sl + 1) % 10; ndx = 1; miss = 1;
                if (m_sl == 0) ev_wrap++;
            end else nbx = m_bx + (m_dx ? 1 : -1);
            if (miss) begin
                ev_miss++; m_play = 0;
                nbx = (xr - 8) / 2; nby = (yr - 8) / 2;
            end
        end
        m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
        m_ly = move_paddle(m_ly, lu, ld);
        m_ry = move_paddle(m_ry, ru, rd);
    endtask

    function automatic logic [11:0] m_pixel(int x, int y);
        if (x >= xr || y >= yr) return 12'h000;
        if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 12'hFFF;
        if (y >= m_ly && y < m_ly + 48 && x >= 16 && x < 24) return 12'h0F0;
        if (y >= m_ry && y < m_ry + 48 && x >= xr - 24 && x < xr - 16) return 12'h0F0;
        if (x == xr / 2 && ((y / 8) % 2) == 0) return 12'h444;
        return 12'h000;
    endfunction

    function automatic logic [63:0] dut_snap();
        return {9'd0, dut.bx, dut.by, dut.ly, dut.ry, dut.dx, dut.dy, 1'(dut.state),
                4'(dut.serve_cnt), scoreL, scoreR};
    endfunction

    function automatic logic [63:0] model_snap();
        return {9'd0, 10'(m_bx), 10'(m_by), 10'(m_ly), 10'(m_ry), 1'(m_dx), 1'(m_dy),
                1'(m_play), 4'(m_cnt), 4'(m_sl), 4'(m_sr)};
    endfunction

    // one vsync falling edge, vsync held low for 'low' clocks
    task automatic do_tick(bit lu, bit ld, bit ru, bit rd, int low);
        @(negedge clock);
        btnLup = lu; btnLdown = ld; btnRup = ru; btnRdown = rd;
        vsync_in = 1'b0;
        repeat (low) @(negedge clock);
        vsync_in = 1'b1;
        m_tick(lu, ld, ru, rd);
    endtask

    task automatic test_reset();
        reset = 1'b0; Xresolution = 10'd640; Yresolution = 10'd480;
        xpos = 10'd316; ypos = 10'd236; hsync_in = 1'b0; vsync_in = 1'b1;
        btnLup = 0; btnLdown = 0; btnRup = 0; btnRdown = 0;
        xr = 640; yr = 480; m_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++; $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
        end
        checks++;
        if ({hsync_out, vsync_out} !== 2'b11) begin
            failures++; $display("FAIL reset_syncs: got %b expected 11", {hsync_out, vsync_out});
        end
        checks++;
        if ({dut.bx, dut.by, dut.ly, dut.ry} !== {10'd316, 10'd236, 10'd216, 10'd216}) begin
            failures++;
            $display("FAIL reset_positions: got bx=%0d by=%0d ly=%0d ry=%0d expected 316 236 216 216",
                     dut.bx, dut.by, dut.ly, dut.ry);
        end
        checks++;
        if (dut_snap() !== model_snap()) begin
            failures++; $display("FAIL reset_state: got %h expected %h", dut_snap(), model_snap());
        end
        reset = 1'b1; hsync_in = 1'b1;
    endtask

    task automatic test_render_fixed();
        int tx[6] = '{16, 700, 320, 320, 316, 320};
        int ty[6] = '{216, 216, 3, 8, 236, 240};
        logic [11:0] te[6] = '{12'h0F0, 12'h000, 12'h444, 12'h000, 12'hFFF, 12'hFFF};
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            xpos = 10'(tx[i]); ypos = 10'(ty[i]);
            @(negedge clock);
            checks++;
            if ({red, green, blue} !== te[i]) begin
                failures++;
                $display("FAIL render_fixed(%0d,%0d): got %h expected %h", tx[i], ty[i], {red, green, blue}, te[i]);
            end
        end
    endtask

    task automatic test_serve_and_move();
        for (int i = 0; i < 3; i++) begin
            do_tick(0, 0, 0, 0, 1);
            checks++;
            if (vsync_out !== 1'b0) begin
                failures++; $display("FAIL serve_vsync_out: got %b expected 0", vsync_out);
            end
            checks++;
            if (dut_snap() !== model_snap()) begin
                failures++; $display("FAIL serve_tick%0d: got %h expected %h", i, dut_snap(), model_snap());
            end
            if (i == 1) begin
                checks++;
                if (1'(dut.state) !== 1'b1) begin
                    failures++; $display("FAIL serve_to_play: got %b expected 1", 1'(dut.state));
                end
            end
        end
        checks++;
        if ({dut.bx, dut.by} !== {10'd317, 10'd237}) begin
            failures++; $display("FAIL first_move: got (%0d,%0d) expected (317,237)", dut.bx, dut.by);
        end
        @(negedge clock);
        xpos = 10'd317; ypos = 10'd237;
        @(negedge clock);
        checks++;
        if ({red, green, blue} !== 12'hFFF) begin
            failures++; $display("FAIL ball_pixel: got %h expected FFF", {red, green, blue});
        end
    endtask

    task automatic test_paddle_saturation();
        for (int i = 0; i < 60; i++) begin
            do_tick(1, 0, 1, 1, 1);
            checks++;
            if (dut_snap() !== model_snap()) begin
                failures++; $display("FAIL paddle_sat_tick%0d: got %h expected %h", i, dut_snap(), model_snap());
            end
        end
        checks++;
        if ({dut.ly, dut.ry} !== {10'd0, 10'd216}) begin
            failures++; $display("FAIL paddle_sat_final: got ly=%0d ry=%0d expected 0 216", dut.ly, dut.ry);
        end
    endtask

    task automatic test_render_stream();
        int px, py;
        logic phs;
        logic [11:0] exp_rgb;
        px = 0; py = 0; phs = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (i > 0) begin
                exp_rgb = m_pixel(px, py);
                checks++;
                if ({red, green, blue} !== exp_rgb) begin
                    failures++;
                    $display("FAIL render_stream(%0d,%0d): got %h expected %h", px, py, {red, green, blue}, exp_rgb);
                end
                checks++;
                if (hsync_out !== phs) begin
                    failures++; $display("FAIL hsync_delay: got %b expected %b", hsync_out, phs);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                px = m_bx - 2 + int'($urandom_range(0, 12)); py = m_by - 2 + int'($urandom_range(0, 12));
            end else begin
                px = int'($urandom_range(0, 799)); py = int'($urandom_range(0, 524));
            end
            phs = 1'($urandom_range(0, 1));
            xpos = 10'(px); ypos = 10'(py); hsync_in = phs;
        end
        @(negedge clock);
        hsync_in = 1'b1;
    endtask

    task automatic test_random_play();
        bit did_reset;
        int px, py;
        logic [11:0] exp_rgb;
        did_reset = 0;
        @(negedge clock);
        reset = 1'b0; Xresolution = 10'd80; Yresolution = 10'd120;
        @(negedge clock);
        reset = 1'b1;
        xr = 80; yr = 120; m_reset();
        checks++;
        if (dut_snap() !== model_snap()) begin
            failures++; $display("FAIL play_reset: got %h expected %h", dut_snap(), model_snap());
        end
        for (int t = 0; t < 6000; t++) begin
            do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            checks++;
            if (dut_snap() !== model_snap()) begin
                failures++; $display("FAIL play_tick%0d: got %h expected %h", t, dut_snap(), model_snap());
            end
            if (t >= 150 && !did_reset && m_play == 1) begin
                did_reset = 1;
                @(negedge clock);
                reset = 1'b0; vsync_in = 1'b0;
                @(negedge clock);
                reset = 1'b1; vsync_in = 1'b1;
                m_reset();
                checks++;
                if ({dut_snap(), vsync_out, red, green, blue} !== {model_snap(), 1'b1, 12'h000}) begin
                    failures++;
                    $display("FAIL midrally_reset: got %h/%b/%h expected %h/1/000",
                             dut_snap(), vsync_out, {red, green, blue}, model_snap());
                end
            end
            if (t % 4 == 0) begin
                @(negedge clock);
                px = m_bx - 2 + int'($urandom_range(0, 12));
                py = (t % 8 == 0) ? int'($urandom_range(0, 127)) : m_by - 2 + int'($urandom_range(0, 12));
                xpos = 10'(px); ypos = 10'(py);
                @(negedge clock);
                exp_rgb = m_pixel(px, py);
                checks++;
                if ({red, green, blue} !== exp_rgb) begin
                    failures++;
                    $display("FAIL play_pixel(%0d,%0d): got %h expected %h", px, py, {red, green, blue}, exp_rgb);
                end
            end
        end
        checks++;
        if (ev_wrap == 0 || ev_hit == 0 || ev_miss == 0) begin
            failures++;
            $display("FAIL play_coverage: got wraps=%0d hits=%0d misses=%0d expected all nonzero",
                     ev_wrap, ev_hit, ev_miss);
        end
    endtask

    initial begin
        test_reset();
        test_render_fixed();
        test_serve_and_move();
        test_paddle_saturation();
        test_render_stream();
        test_random_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
